dynamixel_status_rx: RTL and testbench
======================================

Name: dynamixel_status_rx

Overview:
- Receive side of the Dynamixel protocol 1.0 half-duplex UART link. The servo answers our instruction packets with status packets; this block parses them.
- Oversamples the shared RX line and deframes 8N1 bytes.
- Parses status packets of the form FF FF ID LEN ERR P1..PN CHK, verifies the checksum, and presents ID, error byte and up to 4 parameter bytes to the top level for LEDs and the SPI readback register.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 1000000, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD (50 at default).
- MAX_PARAMS, 4, maximum parameter bytes accepted; LEN legal range is 2..MAX_PARAMS+2.
- TIMEOUT_BITS, 20, maximum idle gap inside a packet, in bit times.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- rx_en  input  1  1 = line owned by servo (UART_DIR in receive). Byte reception is ignored while 0.
- rxd  input  1  raw serial line, idle high.
- pkt_valid  output  1  one-cycle pulse when a good packet completes.
- pkt_id  output  8  ID of the last good packet.
- pkt_error  output  8  servo error byte of the last good packet.
- pkt_nparams  output  3  number of parameters (LEN-2) of the last good packet.
- pkt_params  output  32  P1 in [7:0], P2 in [15:8], and so on. Unused bytes are 0.
- chk_err  output  1  one-cycle pulse on checksum mismatch.
- frame_err  output  1  one-cycle pulse on a bad stop bit or an illegal LEN.
- timeout_err  output  1  one-cycle pulse on an intra-packet timeout.
- busy  output  1  high while the packet FSM is past HDR1.

Behaviour:
- Reset values:
  - All outputs 0.
  - Both FSMs idle.
  - Accumulators and checksum 0.
- Reset mid-byte or mid-packet discards everything. No error pulse is generated.
- Input conditioning: rxd passes through a 2-flop synchronizer. Its output is the only version of rxd used.
- Byte FSM: IDLE, START, DATA, STOP.
  - IDLE to START on a synchronized falling edge while rx_en=1.
  - START: sample at CLKS_PER_BIT/2. Low goes to DATA; high is a glitch and returns to IDLE silently.
  - DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - STOP: sample one bit later. 1 gives byte_done for 1 cycle. 0 gives frame_err pulse, the byte is dropped, and the packet FSM returns to HDR1.
  - Return to IDLE immediately after the stop sample. No wait for the full stop bit.
- rx_en falling mid-byte aborts the byte FSM to IDLE silently. The packet FSM is unaffected, and the timeout still runs.
- Packet FSM: HDR1, HDR2, ID, LEN, ERR, PARAM, CHK. Advances only on byte_done.
  - HDR1: FF goes to HDR2; any other byte stays.
  - HDR2: FF goes to ID; any other byte goes to HDR1.
  - ID: FF stays in ID (extra preamble). Otherwise latch id and go to LEN.
  - LEN: if 2 <= LEN <= MAX_PARAMS+2, latch it and go to ERR. Otherwise frame_err pulse and go to HDR1.
  - ERR: latch it. Go to PARAM if LEN>2, else CHK.
  - PARAM: store the byte at index k, k=0..LEN-3, then go to CHK after the last one.
  - CHK: compare against ~(ID+LEN+ERR+sum P) mod 256.
- On checksum match:
  - Update pkt_id, pkt_error, pkt_nparams and pkt_params. Unfilled param bytes are zeroed.
  - pkt_valid pulses in the cycle after byte_done of the CHK byte.
- On checksum mismatch: chk_err pulses with the same timing. Output registers are unchanged.
- All results go to HDR1 afterwards.
- Checksum is an 8-bit wrapping running sum, cleared on entry to ID.
- Timeout: a counter restarts on every byte_done while the FSM is not in HDR1. It counts only when the byte FSM is IDLE. Reaching TIMEOUT_BITS*CLKS_PER_BIT gives a timeout_err pulse and returns to HDR1.
- Output registers hold their values until the next good packet.
- At most one error pulse is issued per cycle. Error pulses and pkt_valid are mutually exclusive.

Test Plan:
- Ping reply: bytes FF FF 01 02 00 FC at 1 Mbps.
  - Expect one pkt_valid, id=01, error=00, nparams=0, params=0.
- Read reply: FF FF 01 04 00 20 00 DA.
  - Expect pkt_valid, nparams=2, params=32'h0000_0020.
- Bad checksum: FF FF 01 02 00 FB.
  - Expect a chk_err pulse, no pkt_valid, and the outputs still hold the previous packet.
- Extra preamble and noise:
  - Send 55 FF FF FF 01 02 00 FC. Expect pkt_valid with id=01.
  - Apply a 10-cycle low glitch on an idle line. Expect no byte and no error.
- Framing and length:
  - Send FF FF 01 with a stop bit of 0. Expect frame_err.
  - Send FF FF 01 07. Expect frame_err due to LEN>6. Then a valid ping reply is accepted.
- Timeout and reset:
  - Send FF FF 01 04 00 then idle for 1000 cycles. Expect timeout_err after 1000 cycles of idle.
  - Assert reset mid-packet. Expect all outputs 0 and no error pulses; the next valid packet is received correctly.
  - Send a packet with rx_en=0. Expect it to be fully ignored.

Source files
------------

// File: rtl/dynamixel_status_rx.sv
// dynamixel_status_rx: Dynamixel 1.0 status-packet receiver (8N1 deframer + packet parser)
module dynamixel_status_rx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 1000000,
  parameter int MAX_PARAMS   = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_en,
  input  logic        rxd,
  output logic        pkt_valid,
  output logic [7:0]  pkt_id,
  output logic [7:0]  pkt_error,
  output logic [2:0]  pkt_nparams,
  output logic [31:0] pkt_params,
  output logic        chk_err,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        busy
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int CW   = $clog2(CPB + 1);
  localparam int TLIM = TIMEOUT_BITS * CPB;
  localparam int TW   = $clog2(TLIM + 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
  typedef enum logic [2:0] {P_HDR1, P_HDR2, P_ID, P_LEN, P_ERR, P_PARAM, P_CHK} pstate_t;

  bstate_t bstate, bstate_nx;
  pstate_t pstate, pstate_nx;
  logic rx_m, rx_s, rx_d;
  logic [CW-1:0] bcnt;
  logic [2:0] bidx;
  logic [7:0] shreg;
  logic bsample, byte_done, stop_err;
  logic [7:0] csum, id_r, len_r, err_r, pidx;
  logic [31:0] params_r;
  logic [TW-1:0] tcnt;
  logic len_ok, len_bad, chk_ok, chk_bad, tmo;

  assign bsample = (bstate == B_START) ? (bcnt == CW'(CPB / 2 - 1)) : (bcnt == CW'(CPB - 1));
  assign len_ok  = shreg >= 8'd2 && shreg <= 8'(MAX_PARAMS + 2);
  assign busy    = pstate != P_HDR1;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bstate <= B_IDLE;
      pstate <= P_HDR1;
    end else begin
      bstate <= bstate_nx;
      pstate <= pstate_nx;
    end

  always_comb begin
    bstate_nx = bstate;
    if (!rx_en) bstate_nx = B_IDLE;
    else case (bstate)
      B_IDLE:  bstate_nx = (rx_d && !rx_s) ? B_START : B_IDLE;
      B_START: bstate_nx = !bsample ? B_START : rx_s ? B_IDLE : B_DATA;
      B_DATA:  bstate_nx = (bsample && bidx == 3'd7) ? B_STOP : B_DATA;
      B_STOP:  bstate_nx = bsample ? B_IDLE : B_STOP;
      default: bstate_nx = B_IDLE;
    endcase
  end

  // rx_d is only the one-cycle history of rx_s, used for falling-edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {rx_d, rx_s, rx_m} <= 3'b111;
      bcnt      <= '0;
      bidx      <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      stop_err  <= 1'b0;
    end else begin
      {rx_d, rx_s, rx_m} <= {rx_s, rx_m, rxd};
      bcnt      <= (bstate == B_IDLE || bsample) ? '0 : bcnt + 1'b1;
      bidx      <= (bstate == B_DATA) ? bidx + {2'b0, bsample} : '0;
      shreg     <= (bstate == B_DATA && bsample) ? {rx_s, shreg[7:1]} : shreg;
      byte_done <= rx_en && bstate == B_STOP && bsample && rx_s;
      stop_err  <= rx_en && bstate == B_STOP && bsample && !rx_s;
    end

  always_comb begin
    pstate_nx = pstate;
    len_bad   = 1'b0;
    chk_ok    = 1'b0;
    chk_bad   = 1'b0;
    tmo       = 1'b0;
    if (stop_err) pstate_nx = P_HDR1;
    else if (byte_done) case (pstate)
      P_HDR1:  pstate_nx = (shreg == 8'hFF) ? P_HDR2 : P_HDR1;
      P_HDR2:  pstate_nx = (shreg == 8'hFF) ? P_ID : P_HDR1;
      P_ID:    pstate_nx = (shreg == 8'hFF) ? P_ID : P_LEN;
      P_LEN: begin
        len_bad   = !len_ok;
        pstate_nx = len_ok ? P_ERR : P_HDR1;
      end
      P_ERR:   pstate_nx = (len_r > 8'd2) ? P_PARAM : P_CHK;
      P_PARAM: pstate_nx = (pidx == len_r - 8'd3) ? P_CHK : P_PARAM;
      P_CHK: begin
        pstate_nx = P_HDR1;
        chk_ok    = shreg == ~csum;
        chk_bad   = shreg != ~csum;
      end
      default: pstate_nx = P_HDR1;
    endcase
    else if (pstate != P_HDR1 && bstate == B_IDLE && tcnt == TW'(TLIM - 1)) begin
      tmo       = 1'b1;
      pstate_nx = P_HDR1;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      csum        <= '0;
      id_r        <= '0;
      len_r       <= '0;
      err_r       <= '0;
      pidx        <= '0;
      params_r    <= '0;
      tcnt        <= '0;
      pkt_valid   <= 1'b0;
      chk_err     <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      pkt_id      <= '0;
      pkt_error   <= '0;
      pkt_nparams <= '0;
      pkt_params  <= '0;
    end else begin
      if (byte_done) begin
        if (pstate == P_HDR2) begin
          csum     <= '0;
          params_r <= '0;
          pidx     <= '0;
        end
        if ((pstate == P_ID && shreg != 8'hFF) || pstate == P_LEN || pstate == P_ERR || pstate == P_PARAM)
          csum <= csum + shreg;
        if (pstate == P_ID) id_r <= shreg;
        if (pstate == P_LEN) len_r <= shreg;
        if (pstate == P_ERR) err_r <= shreg;
        if (pstate == P_PARAM) begin
          params_r[{pidx[1:0], 3'b000} +: 8] <= shreg;
          pidx <= pidx + 8'd1;
        end
      end
      tcnt        <= (pstate_nx == P_HDR1 || byte_done) ? '0 : (bstate == B_IDLE) ? tcnt + 1'b1 : tcnt;
      pkt_valid   <= chk_ok;
      chk_err     <= chk_bad;
      frame_err   <= stop_err | len_bad;
      timeout_err <= tmo;
      if (chk_ok) begin
        pkt_id      <= id_r;
        pkt_error   <= err_r;
        pkt_nparams <= 3'(len_r - 8'd2);
        pkt_params  <= params_r;
      end
    end
endmodule

// File: tb/tb_dynamixel_status_rx.sv
// tb_dynamixel_status_rx: directed + randomized status packets checked against a byte-level packet model
`timescale 1ns/1ps
module tb_dynamixel_status_rx;
  localparam int CPB = 50;
  localparam logic [63:0] EV_CHK = {8'd2, 56'd0};
  localparam logic [63:0] EV_FRM = {8'd3, 56'd0};
  localparam logic [63:0] EV_TMO = {8'd4, 56'd0};

  logic clk = 0, reset = 1, rx_en = 1, rxd = 1;
  logic pkt_valid, chk_err, frame_err, timeout_err, busy;
  logic [7:0] pkt_id, pkt_error;
  logic [2:0] pkt_nparams;
  logic [31:0] pkt_params;

  always #10 clk = ~clk;

  dynamixel_status_rx dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .rxd(rxd),
    .pkt_valid(pkt_valid), .pkt_id(pkt_id), .pkt_error(pkt_error),
    .pkt_nparams(pkt_nparams), .pkt_params(pkt_params),
    .chk_err(chk_err), .frame_err(frame_err), .timeout_err(timeout_err), .busy(busy)
  );

  int n_checks = 0, n_fail = 0, multi = 0, drd = 0, erd = 0, cyc, np;
  logic [63:0] dutq[$], expq[$];
  logic [7:0] pq[$], body[$];
  int mst = 0;
  logic [7:0] m_id = 0, m_err = 0, id_b, len_b, err_b, chk_b, s;
  logic [2:0] m_np = 0;
  logic [31:0] m_params = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset) begin
      if ($countones({pkt_valid, chk_err, frame_err, timeout_err}) > 1) multi++;
      if (pkt_valid) dutq.push_back({8'd1, pkt_id, pkt_error, 5'd0, pkt_nparams, pkt_params});
      if (chk_err) dutq.push_back(EV_CHK);
      if (frame_err) dutq.push_back(EV_FRM);
      if (timeout_err) dutq.push_back(EV_TMO);
    end

  // Packet model: collects ID, LEN and the LEN bytes that follow, then judges the whole packet at once
  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    logic [7:0] sum;
    logic [31:0] p;
    if (!stop_ok) begin
      expq.push_back(EV_FRM);
      mst = 0;
      return;
    end
    case (mst)
      0: mst = (b == 8'hFF) ? 1 : 0;
      1: begin
        mst = (b == 8'hFF) ? 2 : 0;
        body.delete();
      end
      2: if (b != 8'hFF) begin
        body.push_back(b);
        mst = 3;
      end
      3: if (b < 8'd2 || b > 8'd6) begin
        expq.push_back(EV_FRM);
        mst = 0;
      end else begin
        body.push_back(b);
        mst = 4;
      end
      default: begin
        body.push_back(b);
        if (body.size() == 2 + int'(body[1])) begin
          sum = 0;
          p = 0;
          for (int i = 0; i < body.size() - 1; i++) sum += body[i];
          for (int i = 3; i < body.size() - 1; i++) p[8*(i-3) +: 8] = body[i];
          if (b == ~sum) begin
            m_id = body[0];
            m_err = body[2];
            m_np = 3'(body[1] - 8'd2);
            m_params = p;
            expq.push_back({8'd1, m_id, m_err, 5'd0, m_np, m_params});
          end else expq.push_back(EV_CHK);
          mst = 0;
        end
      end
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop, input int gap);
    rxd = 0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1;
    repeat (gap) @(negedge clk);
    if (rx_en) model_byte(b, stop);
  endtask

  task automatic send_list(input int maxgap);
    foreach (pq[i]) send_byte(pq[i], 1'b1, $urandom_range(2, maxgap));
  endtask

  task automatic compare_events(input string tag);
    repeat (100) @(negedge clk);
    check({tag, "_nev"}, 64'(dutq.size() - drd), 64'(expq.size() - erd));
    while (drd < dutq.size() && erd < expq.size()) begin
      check({tag, "_ev"}, dutq[drd], expq[erd]);
      drd++;
      erd++;
    end
    drd = dutq.size();
    erd = expq.size();
    check({tag, "_outs"}, {pkt_id, pkt_error, pkt_nparams, pkt_params}, {m_id, m_err, m_np, m_params});
    check({tag, "_busy"}, busy, mst != 0);
    check({tag, "_multi"}, multi, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_outs", {pkt_valid, pkt_id, pkt_error, pkt_nparams, pkt_params, chk_err, frame_err, timeout_err, busy}, 0);
    reset = 0;
    repeat (5) @(negedge clk);
    pq = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
    send_list(10);
    compare_events("ping");
    pq = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h00, 8'hDA};
    send_list(10);
    compare_events("read");
    pq = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFB};
    send_list(10);
    compare_events("badchk");
    pq = '{8'h55, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
    send_list(10);
    compare_events("preamble");
    rxd = 0;
    repeat (10) @(negedge clk);
    rxd = 1;
    repeat (200) @(negedge clk);
    compare_events("glitch");
    send_byte(8'hFF, 1'b1, 10);
    send_byte(8'hFF, 1'b1, 10);
    send_byte(8'h01, 1'b0, 10);
    compare_events("stopbit");
    pq = '{8'hFF, 8'hFF, 8'h01, 8'h07};
    send_list(10);
    compare_events("badlen");
    pq = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
    send_list(10);
    compare_events("ping2");
    pq = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00};
    send_list(10);
    cyc = 0;
    while (!timeout_err && cyc < 1300) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_seen", timeout_err, 1);
    check("tmo_window", (cyc >= 900 && cyc <= 1010), 1);
    expq.push_back(EV_TMO);
    mst = 0;
    compare_events("timeout");
    pq = '{8'hFF, 8'hFF, 8'h01, 8'h04};
    send_list(10);
    rxd = 0;
    repeat (150) @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    check("rst_mid_outs", {pkt_valid, pkt_id, pkt_error, pkt_nparams, pkt_params, chk_err, frame_err, timeout_err, busy}, 0);
    rxd = 1;
    repeat (5) @(negedge clk);
    reset = 0;
    mst = 0;
    body.delete();
    m_id = 0;
    m_err = 0;
    m_np = 0;
    m_params = 0;
    compare_events("reset");
    pq = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
    send_list(10);
    compare_events("ping3");
    rx_en = 0;
    pq = '{8'hFF, 8'hFF, 8'h05, 8'h02, 8'h00, 8'hF8};
    send_list(10);
    compare_events("rxen_off");
    rx_en = 1;
    repeat (20) @(negedge clk);
    send_list(10);
    compare_events("rxen_on");
    for (int n = 0; n < 8; n++) begin
      pq.delete();
      if ($urandom_range(0, 3) == 0) pq.push_back(8'($urandom_range(0, 254)));
      id_b = 8'($urandom_range(0, 254));
      pq.push_back(8'hFF);
      pq.push_back(8'hFF);
      pq.push_back(id_b);
      if ($urandom_range(0, 5) == 0) pq.push_back(8'($urandom_range(7, 255)));
      else begin
        np = $urandom_range(0, 4);
        len_b = 8'(np + 2);
        err_b = 8'($urandom_range(0, 255));
        pq.push_back(len_b);
        pq.push_back(err_b);
        s = id_b + len_b + err_b;
        for (int i = 0; i < np; i++) begin
          pq.push_back(8'($urandom_range(0, 255)));
          s += pq[pq.size() - 1];
        end
        chk_b = ~s;
        if ($urandom_range(0, 3) == 0) chk_b ^= 8'($urandom_range(1, 255));
        pq.push_back(chk_b);
      end
      send_list(60);
      compare_events("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
